// File: rtl/aud_speed_dsp.sv
// Variable-speed playback engine: per DAC frame it steps the SRAM read address and shapes the sample.
// Optional feature macro: AUD_DSP_LINEAR_INTERP_EN builds the slow_1 divider and interpolating accumulator.
module aud_speed_dsp #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
) (
    input  logic              i_AUD_BCLK,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic [2:0]        i_speed,
    input  logic              i_fast,
    input  logic              i_slow_0,
    input  logic              i_slow_1,
    input  logic              i_daclrck,
    input  logic [ADDR_W-1:0] i_end_addr,
    input  logic [DATA_W-1:0] i_sram_data,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_dac_data,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PAUSE = 3'd1,
        S_WAIT  = 3'd2,
        S_FETCH = 3'd3,
        S_LATCH = 3'd4,
`ifdef AUD_DSP_LINEAR_INTERP_EN
        S_DIV   = 3'd5,
`endif
        S_OUT   = 3'd6
    } state_t;

    typedef enum logic [1:0] {M_NORM, M_FAST, M_HOLD, M_INTERP} mode_t;

    state_t            state_q, state_d;
    mode_t             mode_q, mode_d, req_mode;
    logic              lrc_q, frame_evt, go_idle;
    logic              first_q, first_d, done_q, done_d;
    logic [2:0]        spd_q, spd_d, k_q, k_d, grp_last;
    logic [3:0]        step;
    logic [ADDR_W:0]   next_addr;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dac_q, dac_d, cur_q, cur_d, prev_q, prev_d;
`ifdef AUD_DSP_LINEAR_INTERP_EN
    logic [DATA_W:0]   diff, quo_q, quo_d, delta_q, delta_d;
    logic [DATA_W+1:0] acc_q, acc_d, acc_sum;
    logic [2:0]        rem_q, rem_d;
    logic [3:0]        shl, divisor;
    logic              neg_q, neg_d;
    logic [4:0]        cnt_q, cnt_d;

    assign diff    = {i_sram_data[DATA_W-1], i_sram_data} - {prev_q[DATA_W-1], prev_q};
    assign shl     = {rem_q, quo_q[DATA_W]};
    assign divisor = {1'b0, spd_q} + 4'd1;
    assign acc_sum = acc_q + {delta_q[DATA_W], delta_q};
`endif

    assign frame_evt = i_daclrck & ~lrc_q;
    // A group spans N frames only in the holding/interpolating modes; otherwise every frame is a group.
    assign grp_last  = (mode_q == M_HOLD || mode_q == M_INTERP) ? spd_q : 3'd0;
    assign step      = (mode_q == M_FAST) ? ({1'b0, spd_q} + 4'd1) : 4'd1;
    assign next_addr = {1'b0, addr_q} + {{(ADDR_W-3){1'b0}}, step};

    always_comb begin
        req_mode = M_NORM;
        if (i_fast) begin
            req_mode = M_FAST;
        end else if (i_slow_0 && i_speed != 3'd0) begin
            req_mode = M_HOLD;
        end else if (i_slow_1 && i_speed != 3'd0) begin
`ifdef AUD_DSP_LINEAR_INTERP_EN
            req_mode = M_INTERP;
`else
            req_mode = M_HOLD;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        first_d = first_q;
        done_d  = 1'b0;
        spd_d   = spd_q;
        k_d     = k_q;
        addr_d  = addr_q;
        dac_d   = dac_q;
        cur_d   = cur_q;
        prev_d  = prev_q;
        go_idle = 1'b0;
`ifdef AUD_DSP_LINEAR_INTERP_EN
        quo_d   = quo_q;
        delta_d = delta_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_WAIT;
                    first_d = 1'b1;
                end
            end
            S_PAUSE: begin
                if (i_stop) begin
                    go_idle = 1'b1;
                end else if (i_start) begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                if (i_stop) begin
                    go_idle = 1'b1;
                end else if (i_pause) begin
                    state_d = S_PAUSE;
                    dac_d   = '0;
                end else begin
                    case (state_q)
                        S_WAIT: begin
                            if (frame_evt) begin
                                state_d = S_FETCH;
                                if (first_q) begin
                                    first_d = 1'b0;
                                    k_d     = 3'd0;
                                    mode_d  = req_mode;
                                    spd_d   = i_speed;
                                end else if (k_q == grp_last) begin
                                    if (next_addr > {1'b0, i_end_addr}) begin
                                        go_idle = 1'b1;
                                        done_d  = 1'b1;
                                    end else begin
                                        addr_d = next_addr[ADDR_W-1:0];
                                        k_d    = 3'd0;
                                        mode_d = req_mode;
                                        spd_d  = i_speed;
                                    end
                                end else begin
                                    k_d = k_q + 3'd1;
                                end
                            end
                        end
                        S_FETCH: state_d = S_LATCH;
                        S_LATCH: begin
                            cur_d   = i_sram_data;
                            state_d = S_OUT;
`ifdef AUD_DSP_LINEAR_INTERP_EN
                            if (mode_q == M_INTERP && k_q == 3'd0) begin
                                neg_d   = diff[DATA_W];
                                quo_d   = diff[DATA_W] ? -diff : diff;
                                rem_d   = 3'd0;
                                cnt_d   = 5'd0;
                                state_d = S_DIV;
                            end
`endif
                        end
`ifdef AUD_DSP_LINEAR_INTERP_EN
                        S_DIV: begin
                            // Restoring divide of |cur-prev| by N, one quotient bit per cycle.
                            if (shl >= divisor) begin
                                rem_d = 3'(shl - divisor);
                                quo_d = {quo_q[DATA_W-1:0], 1'b1};
                            end else begin
                                rem_d = shl[2:0];
                                quo_d = {quo_q[DATA_W-1:0], 1'b0};
                            end
                            cnt_d = cnt_q + 5'd1;
                            if (cnt_q == 5'(DATA_W)) begin
                                state_d = S_OUT;
                            end
                        end
`endif
                        S_OUT: begin
                            state_d = S_WAIT;
                            dac_d   = cur_q;
                            if (k_q == 3'd0) begin
                                prev_d = cur_q;
                            end
`ifdef AUD_DSP_LINEAR_INTERP_EN
                            if (mode_q == M_INTERP) begin
                                if (k_q == 3'd0) begin
                                    delta_d = neg_q ? -quo_q : quo_q;
                                    acc_d   = {{2{prev_q[DATA_W-1]}}, prev_q};
                                    dac_d   = prev_q;
                                end else begin
                                    acc_d = acc_sum;
                                    if (acc_sum[DATA_W+1:DATA_W-1] == 3'b000 ||
                                        acc_sum[DATA_W+1:DATA_W-1] == 3'b111) begin
                                        dac_d = acc_sum[DATA_W-1:0];
                                    end else if (acc_sum[DATA_W+1]) begin
                                        dac_d = {1'b1, {(DATA_W-1){1'b0}}};
                                    end else begin
                                        dac_d = {1'b0, {(DATA_W-1){1'b1}}};
                                    end
                                end
                            end
`endif
                        end
                        default: state_d = S_WAIT;
                    endcase
                end
            end
        endcase
        if (go_idle) begin
            state_d = S_IDLE;
            addr_d  = '0;
            dac_d   = '0;
            k_d     = 3'd0;
            prev_d  = '0;
        end
    end

    always_ff @(posedge i_AUD_BCLK or posedge i_rst_n) begin
        if (i_rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= M_NORM;
            lrc_q   <= 1'b0;
            first_q <= 1'b0;
            done_q  <= 1'b0;
            spd_q   <= 3'd0;
            k_q     <= 3'd0;
            addr_q  <= '0;
            dac_q   <= '0;
            cur_q   <= '0;
            prev_q  <= '0;
`ifdef AUD_DSP_LINEAR_INTERP_EN
            quo_q   <= '0;
            delta_q <= '0;
            acc_q   <= '0;
            rem_q   <= 3'd0;
            neg_q   <= 1'b0;
            cnt_q   <= 5'd0;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            lrc_q   <= i_daclrck;
            first_q <= first_d;
            done_q  <= done_d;
            spd_q   <= spd_d;
            k_q     <= k_d;
            addr_q  <= addr_d;
            dac_q   <= dac_d;
            cur_q   <= cur_d;
            prev_q  <= prev_d;
`ifdef AUD_DSP_LINEAR_INTERP_EN
            quo_q   <= quo_d;
            delta_q <= delta_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign o_sram_addr = addr_q;
    assign o_dac_data  = dac_q;
    assign o_busy      = (state_q != S_IDLE);
    assign o_done      = done_q;

endmodule

// File: tb/tb_aud_speed_dsp.sv
// Directed bench for aud_speed_dsp: SRAM model with one-cycle read latency, 50-cycle DAC frames.
// Interpolation expectations switch with AUD_DSP_LINEAR_INTERP_EN.
module tb_aud_speed_dsp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, pause = 1'b0, stop = 1'b0;
    logic [2:0]  speed = 3'd0;
    logic        fast = 1'b0, slow0 = 1'b0, slow1 = 1'b0;
    logic        lrc = 1'b0;
    logic [19:0] end_addr = 20'd0;
    logic [15:0] sram_q = 16'd0;
    logic [19:0] addr;
    logic [15:0] dac;
    logic        busy, done;
    logic [15:0] mem [0:63];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) sram_q <= mem[addr[5:0]];

    aud_speed_dsp dut (
        .i_AUD_BCLK (clk),
        .i_rst_n    (rst),
        .i_start    (start),
        .i_pause    (pause),
        .i_stop     (stop),
        .i_speed    (speed),
        .i_fast     (fast),
        .i_slow_0   (slow0),
        .i_slow_1   (slow1),
        .i_daclrck  (lrc),
        .i_end_addr (end_addr),
        .i_sram_data(sram_q),
        .o_sram_addr(addr),
        .o_dac_data (dac),
        .o_busy     (busy),
        .o_done     (done)
    );

    task automatic chk_d(input logic [15:0] obs, input logic [15:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input logic [19:0] obs, input logic [19:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic st, input logic pa, input logic sp);
        start = st; pause = pa; stop = sp;
        @(negedge clk);
        start = 1'b0; pause = 1'b0; stop = 1'b0;
    endtask

    // One frame; lat>0 also checks the update lands exactly lat cycles after the event.
    task automatic frame(input logic [15:0] exp_d, input logic [19:0] exp_a, input int lat,
                         input logic [15:0] old_d, input string tag);
        lrc = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            if (lat > 0 && i == lat) chk_d(dac, old_d, {tag, "_pre"});
            if (lat > 0 && i == lat + 1) chk_d(dac, exp_d, {tag, "_lat"});
        end
        chk_d(dac, exp_d, tag);
        chk_a(addr, exp_a, {tag, "_addr"});
        $display("frame %s dac=%h addr=%0d busy=%b", tag, dac, addr, busy);
        lrc = 1'b0;
        repeat (25) @(negedge clk);
    endtask

    task automatic done_frame(input string tag);
        lrc = 1'b1;
        @(negedge clk);
        chk_a({19'd0, done}, 20'd1, {tag, "_done"});
        chk_a({19'd0, busy}, 20'd0, {tag, "_busy"});
        chk_d(dac, 16'd0, {tag, "_dac"});
        chk_a(addr, 20'd0, {tag, "_addr"});
        @(negedge clk);
        chk_a({19'd0, done}, 20'd0, {tag, "_done_off"});
        $display("frame %s end of recording", tag);
        repeat (22) @(negedge clk);
        lrc = 1'b0;
        repeat (25) @(negedge clk);
    endtask

    initial begin
        for (int a = 0; a < 64; a++) mem[a] = 16'(a);
        repeat (3) @(negedge clk);
        chk_d(dac, 16'd0, "rst_dac");
        chk_a(addr, 20'd0, "rst_addr");
        chk_a({19'd0, busy}, 20'd0, "rst_busy");
        chk_a({19'd0, done}, 20'd0, "rst_done");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // normal play 0..9 then end
        end_addr = 20'd9;
        pulse(1'b1, 1'b0, 1'b0);
        chk_a({19'd0, busy}, 20'd1, "norm_busy");
        for (int i = 0; i < 10; i++)
            frame(16'(i), 20'(i), 3, (i == 0) ? 16'd0 : 16'(i - 1), $sformatf("norm%0d", i));
        done_frame("norm_end");

        // fast x3
        fast = 1'b1; speed = 3'd2; end_addr = 20'd10;
        pulse(1'b1, 1'b0, 1'b0);
        frame(16'd0, 20'd0, 3, 16'd0, "fast0");
        frame(16'd3, 20'd3, 3, 16'd0, "fast1");
        frame(16'd6, 20'd6, 3, 16'd3, "fast2");
        frame(16'd9, 20'd9, 3, 16'd6, "fast3");
        done_frame("fast_end");

        // slow_0 hold x4
        fast = 1'b0; slow0 = 1'b1; speed = 3'd3; end_addr = 20'd9;
        mem[0] = 16'd100; mem[1] = 16'd200;
        pulse(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) frame(16'd100, 20'd0, 3, (i == 0) ? 16'd0 : 16'd100, $sformatf("hold_a%0d", i));
        for (int i = 0; i < 4; i++) frame(16'd200, 20'd1, 3, (i == 0) ? 16'd100 : 16'd200, $sformatf("hold_b%0d", i));
        pulse(1'b0, 1'b0, 1'b1);
        chk_a({19'd0, busy}, 20'd0, "hold_stop_busy");

        // slow_1
        slow0 = 1'b0; slow1 = 1'b1; speed = 3'd3;
        mem[0] = 16'd100; mem[1] = 16'hFF9C;
        pulse(1'b1, 1'b0, 1'b0);
`ifdef AUD_DSP_LINEAR_INTERP_EN
        frame(16'd0,    20'd0, 20, 16'd0,    "lin0");
        frame(16'd25,   20'd0, 3,  16'd0,    "lin1");
        frame(16'd50,   20'd0, 3,  16'd25,   "lin2");
        frame(16'd75,   20'd0, 3,  16'd50,   "lin3");
        frame(16'd100,  20'd1, 20, 16'd75,   "lin4");
        frame(16'd50,   20'd1, 3,  16'd100,  "lin5");
        frame(16'd0,    20'd1, 3,  16'd50,   "lin6");
        frame(16'hFFCE, 20'd1, 3,  16'd0,    "lin7");
`else
        for (int i = 0; i < 4; i++) frame(16'd100, 20'd0, 3, (i == 0) ? 16'd0 : 16'd100, $sformatf("s1_a%0d", i));
        for (int i = 0; i < 4; i++) frame(16'hFF9C, 20'd1, 3, (i == 0) ? 16'd100 : 16'hFF9C, $sformatf("s1_b%0d", i));
`endif
        // stop beats start
        pulse(1'b1, 1'b0, 1'b1);
        chk_a({19'd0, busy}, 20'd0, "conf_busy");
        chk_a(addr, 20'd0, "conf_addr");
        chk_d(dac, 16'd0, "conf_dac");

        // pause / resume
        slow1 = 1'b0; speed = 3'd0; end_addr = 20'd20;
        mem[0] = 16'd0; mem[1] = 16'd1;
        pulse(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)
            frame(16'(i), 20'(i), 3, (i == 0) ? 16'd0 : 16'(i - 1), $sformatf("pp%0d", i));
        pulse(1'b0, 1'b1, 1'b0);
        chk_a({19'd0, busy}, 20'd1, "pause_busy");
        chk_d(dac, 16'd0, "pause_dac");
        for (int i = 0; i < 10; i++) frame(16'd0, 20'd5, 0, 16'd0, $sformatf("paused%0d", i));
        pulse(1'b1, 1'b0, 1'b0);
        frame(16'd6, 20'd6, 3, 16'd0, "resume6");
        frame(16'd7, 20'd7, 3, 16'd6, "resume7");
        // pause beats start
        pulse(1'b1, 1'b1, 1'b0);
        chk_d(dac, 16'd0, "pvs_dac");
        chk_a({19'd0, busy}, 20'd1, "pvs_busy");
        chk_a(addr, 20'd7, "pvs_addr");
        pulse(1'b0, 1'b0, 1'b1);
        chk_a({19'd0, busy}, 20'd0, "pstop_busy");

        // end_addr == 0
        end_addr = 20'd0; mem[0] = 16'h1234;
        pulse(1'b1, 1'b0, 1'b0);
        frame(16'h1234, 20'd0, 3, 16'd0, "end0");
        done_frame("end0_done");

        // asynchronous reset mid-frame (mid-divide when interpolating)
        end_addr = 20'd9; mem[1] = 16'd500;
        pulse(1'b1, 1'b0, 1'b0);
        frame(16'h1234, 20'd0, 3, 16'd0, "rr0");
        slow1 = 1'b1; speed = 3'd3;
        lrc = 1'b1;
        repeat (10) @(negedge clk);
`ifdef AUD_DSP_LINEAR_INTERP_EN
        chk_d(dac, 16'h1234, "rr_pre_dac");
`else
        chk_d(dac, 16'd500, "rr_pre_dac");
`endif
        chk_a(addr, 20'd1, "rr_pre_addr");
        rst = 1'b1;
        #1;
        chk_d(dac, 16'd0, "rr_dac");
        chk_a(addr, 20'd0, "rr_addr");
        chk_a({19'd0, busy}, 20'd0, "rr_busy");
        chk_a({19'd0, done}, 20'd0, "rr_done");
        @(negedge clk);
        lrc = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_a({19'd0, busy}, 20'd0, "rr_after_busy");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aud_speed_dsp.md
# aud_speed_dsp

- Sits between the recording SRAM and the I2S audio player.
- Once per DAC frame, computes the next SRAM read address for normal, fast (1x–8x) or slow (1/1–1/8) playback.
- Fetches the sample and, for slow play, applies sample-hold or linear interpolation.
- Presents one signed 16-bit sample per frame to the player on o_dac_data.

## Interface
- ADDR_W, 20, SRAM word-address width
- DATA_W, 16, sample width, two's complement
- i_AUD_BCLK  in  1  audio bit clock; the only clock
- i_rst_n  in  1  reset, asynchronous, active-high
- i_start  in  1  one-cycle pulse; begin playback from IDLE or resume from PAUSE
- i_pause  in  1  one-cycle pulse; freeze position
- i_stop  in  1  one-cycle pulse; abort and rewind
- i_speed  in  3  speed index s; factor N = s+1
- i_fast / i_slow_0 / i_slow_1  in  1 each  mode flags; priority fast > slow_0 > slow_1; none set = normal
- i_daclrck  in  1  DAC LR clock; frame event = 0→1 transition sampled on BCLK
- i_end_addr  in  ADDR_W  last valid recorded address
- i_sram_data  in  DATA_W  SRAM read data; valid one BCLK after o_sram_addr changes
- o_sram_addr  out  ADDR_W  read address
- o_dac_data  out  DATA_W  sample to player
- o_busy  out  1  high in PLAY or PAUSE
- o_done  out  1  one-cycle pulse when playback reaches end of recording

## Operation
**Reset values:** o_sram_addr=0, o_dac_data=0, o_busy=0, o_done=0. Internal prev/cur/delta/acc/k are all 0.

**Top FSM**
- IDLE: start→PLAY.
- PLAY: stop→IDLE; pause→PAUSE.
- PAUSE: stop→IDLE; start→PLAY.
- Stop beats pause and start when asserted in the same cycle. Pause beats start.
- Entering IDLE: o_sram_addr=0, o_dac_data=0, k=0, prev=0.
- In PAUSE: o_dac_data=0. Address, k, prev and acc are held, so playback resumes seamlessly.

**Frame sub-FSM (PLAY only):** WAIT_LRC → FETCH → LATCH → (DIV) → OUT → WAIT_LRC.

**Step rules** (mode and i_speed are sampled only when k==0, i.e. at a source-sample boundary):
- Normal: advance 1 address per frame; o_dac_data = cur.
- Fast: advance N addresses per frame; o_dac_data = cur (decimation, no filtering).
- slow_0: hold each source sample for N frames (k = 0..N-1), then advance 1; o_dac_data = cur.
- slow_1, at k==0:
  - delta = (cur − prev) as 17-bit signed, divided by N, truncated toward zero.
  - Division is a sequential restoring divider, 17 cycles (state DIV).
  - acc = prev; output acc; each later frame acc += delta; output saturated to 16-bit signed.
  - At the end of the group, prev ← cur.
- N=1 in any slow mode behaves exactly like normal.

**End of recording**
- The step that would make the address exceed i_end_addr ends playback instead of advancing.
- That frame outputs 0, o_done pulses, and the FSM goes to IDLE.
- If i_end_addr==0: one frame plays address 0, then done.

**Mid-operation events**
- A start/pause/stop pulse mid-frame takes effect the next cycle. An in-flight fetch or divide is discarded.
- Reset mid-operation returns everything to reset values immediately.

## Timing
- Frame event to SRAM address valid: 1 cycle (FETCH). Data latched at LATCH, 2 cycles after the event.
- o_dac_data update after frame event:
  - 3 cycles in normal, fast and slow_0.
  - 20 cycles in slow_1 at k==0.
  - 3 cycles in slow_1 for k>0.
- o_dac_data is held stable until the next update.
- Requirement on the driver: i_daclrck period ≥ 48 BCLK cycles. A frame event that arrives while not in WAIT_LRC is dropped.
- o_done is high for exactly 1 cycle, coincident with the state becoming IDLE.

## Configuration
- **AUD_DSP_LINEAR_INTERP_EN defined:** slow_1 performs linear interpolation as above; the divider and accumulator are built.
- **Not defined:** slow_1 behaves identically to slow_0; the DIV state and divider are removed, and every update is 3 cycles after the frame event.

## Test plan
- **Normal play:** SRAM[a]=a, end_addr=9, start.
  - o_dac_data = 0,1,…,9 on successive frames.
  - Then a frame of 0, o_done pulse, o_busy=0.
- **Fast:** i_fast=1, s=2, SRAM[a]=a, end_addr=10.
  - Outputs 0,3,6,9, then done.
  - Address never exceeds 10.
- **slow_0:** s=3, SRAM[0..1]=100,200.
  - Outputs 100×4, then 200×4.
- **slow_1** (macro defined): s=3, prev=0, SRAM[0]=100.
  - Outputs 0,25,50,75; the k==0 update lands 20 cycles after the frame event.
  - Then for SRAM[1]=−100: 100,50,0,−50.
- **Pause/resume:** pause at the frame showing 5.
  - o_dac_data=0, address held for 10 frames.
  - start → next frame outputs 6.
- **Conflicts and reset:**
  - stop and start in the same cycle during PLAY → IDLE, address 0.
  - i_rst_n asserted mid-DIV → all outputs return to reset values immediately.
